// File: rtl/ic_result_uart_tx.sv
// ic_result_uart_tx
// Snapshots the gate-tester result on an accepted start pulse and sends it to
// the host as a fixed 5-byte 8N1 UART frame:
//   B0 = HEADER
//   B1 = {1'b0, gate_select, 1'b0, pass_vec}
//   B2 = {5'b0, fail_vec}
//   B3 = expected
//   B4 = B1 ^ B2 ^ B3
// Bytes go LSB first, back to back with no idle gap between them. Every output
// comes straight from a flop, so tx stays glitch-free.
module ic_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,   // legal range 2..65535
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,        // synchronous, active-high
  input  logic       start,
  input  logic [2:0] gate_select,
  input  logic [2:0] pass_vec,
  input  logic [2:0] fail_vec,
  input  logic [7:0] expected,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // Last value of the baud counter inside one bit period.
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  // Index of the final byte, the checksum.
  localparam logic [2:0]  LAST_BYTE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e      state_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] baud_q;      // cycles elapsed in the current bit
  logic [2:0]  bit_cnt_q;   // data bit being sent, 0..7
  logic [2:0]  byte_idx_q;  // byte being sent, 0..4
  logic [7:0]  data_sr_q;   // remaining data bits of the current byte
  logic [31:0] shadow_q;    // {B4, B3, B2, B1}, captured at accept

  logic [7:0]  b1;
  logic [7:0]  b2;
  logic [7:0]  b3;
  logic [31:0] shadow_d;
  logic [7:0]  cur_byte;
  logic        bit_end;

  // Assemble the payload bytes and checksum from the live inputs.
  always_comb begin
    b1       = {1'b0, gate_select, 1'b0, pass_vec};
    b2       = {5'b0, fail_vec};
    b3       = expected;
    shadow_d = {b1 ^ b2 ^ b3, b3, b2, b1};
  end

  // Select the byte addressed by the byte index; B0 is the constant header.
  always_comb begin
    // NOTE: every path assigns cur_byte (default arm included), so no latch is inferred.
    case (byte_idx_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = shadow_q[7:0];
      3'd2:    cur_byte = shadow_q[15:8];
      3'd3:    cur_byte = shadow_q[23:16];
      3'd4:    cur_byte = shadow_q[31:24];
      default: cur_byte = HEADER;
    endcase
  end

  // High on the final cycle of each bit period.
  assign bit_end = (baud_q == BAUD_LAST);

  // Frame sequencer: walks start, data and stop bits and drives the registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every read in
    // this block sees the value from before the edge.
    if (reset) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      data_sr_q  <= '0;
      // NOTE: shadow_q is left out of reset on purpose. It is pure payload and
      // is always reloaded before it is read.
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (start) begin
            shadow_q   <= shadow_d;
            state_q    <= S_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
            tx_q      <= cur_byte[0];
            data_sr_q <= {1'b0, cur_byte[7:1]};
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= data_sr_q[0];
              data_sr_q <= {1'b0, data_sr_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (byte_idx_q < LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 3'd1;
              state_q    <= S_START;
              tx_q       <= 1'b0;
            end else begin
              // Frame complete: busy drops with done, so a start seen during
              // the done cycle is accepted on the next edge.
              byte_idx_q <= '0;
              state_q    <= S_IDLE;
              tx_q       <= 1'b1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
